// File: rtl/fc_decoder_pkg.sv
// Shared definitions for the fast-control decoder: command bit positions,
// lock FSM state codes, counter widths and a saturating adder.
package fc_decoder_pkg;

  localparam int CMD_BCR          = 0;
  localparam int CMD_L1A          = 1;
  localparam int CMD_LINK_RESET   = 2;
  localparam int CMD_BUFFER_CLEAR = 3;
  localparam int CMD_CALIB        = 5;

  localparam int ENC_W     = 16;
  localparam int BX_W      = 12;
  localparam int L1A_CNT_W = 32;
  localparam int ERR_CNT_W = 16;
  localparam int MIS_CNT_W = 16;
  localparam int RUN_W     = 8;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  // Adds 0..3 and clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] value, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, value} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/fc_decoder_hamming84_dec.sv
// Extended Hamming(8,4) decoder: bit 0 overall parity, bits 1/2/4 parity,
// bits 3/5/6/7 data. Corrects one error, flags two.
module hamming84_dec
  import fc_decoder_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [3:0] o_data,
  output logic       o_sbe,
  output logic       o_dbe
);

  logic [2:0] w_syn;
  logic       w_par;
  logic [7:0] w_fixed;

  // Odd overall parity means one flipped bit at the syndrome position
  // (syndrome 0 points at the parity bit itself, which carries no data).
  always_comb begin
    w_syn[0] = i_code[1] ^ i_code[3] ^ i_code[5] ^ i_code[7];
    w_syn[1] = i_code[2] ^ i_code[3] ^ i_code[6] ^ i_code[7];
    w_syn[2] = i_code[4] ^ i_code[5] ^ i_code[6] ^ i_code[7];
    w_par    = ^i_code;
    w_fixed  = i_code;
    if (w_par) begin
      w_fixed[w_syn] = ~i_code[w_syn];
    end
    o_sbe  = w_par;
    o_dbe  = ~w_par & (w_syn != 3'd0);
    o_data = {w_fixed[7], w_fixed[6], w_fixed[5], w_fixed[3]};
  end

endmodule

// File: rtl/fc_decoder.sv
// Fast-control decoder: Hamming-protected command word, BX counter, BCR lock FSM
// and event counters. Define FC_DECODER_ERR_CNT_EN to implement sbe/dbe counters.
module fc_decoder
  import fc_decoder_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                 clk_bx,
  input  logic                 reset,
  input  logic [ENC_W-1:0]     fc_stream_enc,
  input  logic [BX_W-1:0]      orb_length,
  input  logic                 clear_counters,
  output logic                 bcr,
  output logic                 l1a,
  output logic                 link_reset,
  output logic                 buffer_clear,
  output logic                 calib_pulse,
  output logic [BX_W-1:0]      bxid,
  output logic                 locked,
  output logic [L1A_CNT_W-1:0] l1a_count,
  output logic [ERR_CNT_W-1:0] sbe_count,
  output logic [ERR_CNT_W-1:0] dbe_count,
  output logic [MIS_CNT_W-1:0] misalign_count
);

  localparam logic [RUN_W-1:0] LOCK_N   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_N = RUN_W'(UNLOCK_COUNT);

  logic [ENC_W-1:0]     r_enc;
  logic [3:0]           w_lo_data, w_hi_data;
  logic                 w_lo_sbe, w_hi_sbe, w_lo_dbe, w_hi_dbe;
  logic                 w_dbe, w_bcr, w_l1a_out, w_last_bx, w_aligned, w_misalign;
  logic [7:0]           w_cmd;
  logic                 w_unused_cmd;
  logic [1:0]           r_state;
  logic [RUN_W-1:0]     r_run, r_miss;
  logic                 r_bcr, r_l1a, r_link_reset, r_buffer_clear, r_calib;
  logic [BX_W-1:0]      r_bxid;
  logic [L1A_CNT_W-1:0] r_l1a_cnt;
  logic [MIS_CNT_W-1:0] r_mis_cnt;

  always_ff @(posedge clk_bx) begin
    if (reset) r_enc <= '0;
    else       r_enc <= fc_stream_enc;
  end

  hamming84_dec u_dec_lo (.i_code(r_enc[7:0]),  .o_data(w_lo_data), .o_sbe(w_lo_sbe), .o_dbe(w_lo_dbe));
  hamming84_dec u_dec_hi (.i_code(r_enc[15:8]), .o_data(w_hi_data), .o_sbe(w_hi_sbe), .o_dbe(w_hi_dbe));

  // An uncorrectable nibble poisons the whole word.
  assign w_dbe        = w_lo_dbe | w_hi_dbe;
  assign w_cmd        = w_dbe ? 8'h00 : {w_hi_data, w_lo_data};
  assign w_unused_cmd = w_cmd[4] ^ w_cmd[6] ^ w_cmd[7];
  assign w_bcr        = w_cmd[CMD_BCR];
  assign w_last_bx    = (r_bxid == orb_length - 12'd1);
  assign w_aligned    = w_bcr & w_last_bx;
  assign w_misalign   = (r_state == ST_LOCKED) & (w_bcr ^ w_last_bx);
  assign w_l1a_out    = w_cmd[CMD_L1A] & (r_state == ST_LOCKED);

  always_ff @(posedge clk_bx) begin
    if (reset || w_cmd[CMD_LINK_RESET]) begin
      r_state <= ST_UNLOCKED;
      r_run   <= '0;
      r_miss  <= '0;
    end else begin
      case (r_state)
        ST_UNLOCKED: if (w_bcr) begin
          r_state <= ST_CHECK;
          r_run   <= '0;
        end
        ST_CHECK: if (w_bcr) begin
          if (!w_last_bx) begin
            r_run <= '0;
          end else if (r_run + 8'd1 >= LOCK_N) begin
            r_state <= ST_LOCKED;
            r_run   <= '0;
            r_miss  <= '0;
          end else begin
            r_run <= r_run + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (w_aligned) begin
            r_miss <= '0;
          end else if (w_misalign) begin
            if (r_miss + 8'd1 >= UNLOCK_N) begin
              r_state <= ST_UNLOCKED;
              r_miss  <= '0;
            end else begin
              r_miss <= r_miss + 8'd1;
            end
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_bcr          <= 1'b0;
      r_l1a          <= 1'b0;
      r_link_reset   <= 1'b0;
      r_buffer_clear <= 1'b0;
      r_calib        <= 1'b0;
      r_bxid         <= '0;
    end else begin
      r_bcr          <= w_bcr;
      r_l1a          <= w_l1a_out;
      r_link_reset   <= w_cmd[CMD_LINK_RESET];
      r_buffer_clear <= w_cmd[CMD_BUFFER_CLEAR];
      r_calib        <= w_cmd[CMD_CALIB];
      r_bxid         <= (w_bcr || w_last_bx) ? '0 : r_bxid + 12'd1;
    end
  end

  always_ff @(posedge clk_bx) begin
    if (reset || clear_counters) begin
      r_l1a_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_l1a_out && (r_l1a_cnt != '1)) r_l1a_cnt <= r_l1a_cnt + 32'd1;
      r_mis_cnt <= sat_add16(r_mis_cnt, {1'b0, w_misalign});
    end
  end

`ifdef FC_DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_sbe_cnt, r_dbe_cnt;

  always_ff @(posedge clk_bx) begin
    if (reset || clear_counters) begin
      r_sbe_cnt <= '0;
      r_dbe_cnt <= '0;
    end else begin
      r_sbe_cnt <= sat_add16(r_sbe_cnt, {1'b0, w_lo_sbe} + {1'b0, w_hi_sbe});
      r_dbe_cnt <= sat_add16(r_dbe_cnt, {1'b0, w_dbe});
    end
  end

  assign sbe_count = r_sbe_cnt;
  assign dbe_count = r_dbe_cnt;
`else
  logic w_unused_sbe;
  assign w_unused_sbe = w_lo_sbe ^ w_hi_sbe;
  assign sbe_count    = '0;
  assign dbe_count    = '0;
`endif

  assign bcr            = r_bcr;
  assign l1a            = r_l1a;
  assign link_reset     = r_link_reset;
  assign buffer_clear   = r_buffer_clear;
  assign calib_pulse    = r_calib;
  assign bxid           = r_bxid;
  assign locked         = (r_state == ST_LOCKED);
  assign l1a_count      = r_l1a_cnt;
  assign misalign_count = r_mis_cnt;

endmodule

// File: tb/tb_fc_decoder.sv
// Directed bench for fc_decoder: a cycle model built from the command rules
// (intended command plus number of flipped bits per nibble) checks every output.
module tb_fc_decoder;

  localparam int ORB     = 45;
  localparam int LOCKN   = 3;
  localparam int UNLOCKN = 2;
  localparam int UNL     = 0;
  localparam int CHK     = 1;
  localparam int LCK     = 2;
`ifdef FC_DECODER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_bx = 1'b0;
  logic        reset;
  logic [15:0] fc_stream_enc;
  logic [11:0] orb_length;
  logic        clear_counters;
  logic        bcr, l1a, link_reset, buffer_clear, calib_pulse, locked;
  logic [11:0] bxid;
  logic [31:0] l1a_count;
  logic [15:0] sbe_count, dbe_count, misalign_count;

  always #5 clk_bx = ~clk_bx;

  fc_decoder #(.LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN)) dut (
    .clk_bx(clk_bx), .reset(reset), .fc_stream_enc(fc_stream_enc),
    .orb_length(orb_length), .clear_counters(clear_counters),
    .bcr(bcr), .l1a(l1a), .link_reset(link_reset), .buffer_clear(buffer_clear),
    .calib_pulse(calib_pulse), .bxid(bxid), .locked(locked),
    .l1a_count(l1a_count), .sbe_count(sbe_count), .dbe_count(dbe_count),
    .misalign_count(misalign_count)
  );

  int compared = 0;
  int failed   = 0;
  bit checkOn  = 1'b0;

  logic [7:0] curCmd = 8'h00;
  int         curFlo = 0;
  int         curFhi = 0;

  logic [7:0] sCmd = 8'h00;
  int         sFlo = 0, sFhi = 0;
  int         mBx = 0, mMode = UNL, mRun = 0, mMiss = 0;
  longint     cL1a = 0, cSbe = 0, cDbe = 0, cMis = 0;
  logic       eBcr = 0, eL1a = 0, eLr = 0, eBc = 0, eCal = 0;

  function automatic logic [7:0] ham84(input logic [3:0] d);
    logic [7:0] c;
    c    = 8'h00;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [7:0] flipMask(input bit hiNib, input int n);
    if (n == 0) return 8'h00;
    if (n == 1) return hiNib ? 8'h08 : 8'h20;
    return hiNib ? 8'h90 : 8'h42;
  endfunction

  function automatic longint satAt(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int flo, input int fhi,
                               input logic clr, input logic rst);
    @(posedge clk_bx);
    #1;
    reset          = rst;
    clear_counters = clr;
    fc_stream_enc  = {ham84(cmd[7:4]) ^ flipMask(1'b1, fhi), ham84(cmd[3:0]) ^ flipMask(1'b0, flo)};
    curCmd         = cmd;
    curFlo         = flo;
    curFhi         = fhi;
  endtask

  // Reference: a word reaches the outputs one edge after it is captured.
  always @(posedge clk_bx) begin : refModel
    automatic logic [7:0] c = 8'h00;
    automatic bit dbeW = 1'b0, lastBx = 1'b0, wasLocked = 1'b0, mis = 1'b0;
    automatic int nMode = UNL, nRun = 0, nMiss = 0;
    if (reset) begin
      sCmd <= 8'h00; sFlo <= 0; sFhi <= 0;
      mBx <= 0; mMode <= UNL; mRun <= 0; mMiss <= 0;
      cL1a <= 0; cSbe <= 0; cDbe <= 0; cMis <= 0;
      eBcr <= 0; eL1a <= 0; eLr <= 0; eBc <= 0; eCal <= 0;
    end else begin
      dbeW      = (sFlo >= 2) || (sFhi >= 2);
      c         = dbeW ? 8'h00 : sCmd;
      lastBx    = (mBx == ORB - 1);
      wasLocked = (mMode == LCK);
      mis       = wasLocked && (c[0] != lastBx);
      nMode = mMode; nRun = mRun; nMiss = mMiss;
      if (c[2]) begin
        nMode = UNL; nRun = 0; nMiss = 0;
      end else if (mMode == UNL) begin
        if (c[0]) begin nMode = CHK; nRun = 0; end
      end else if (mMode == CHK) begin
        if (c[0] && lastBx) begin
          nRun = mRun + 1;
          if (nRun == LOCKN) begin nMode = LCK; nRun = 0; nMiss = 0; end
        end else if (c[0]) nRun = 0;
      end else begin
        if (c[0] && lastBx) nMiss = 0;
        else if (mis) begin
          nMiss = mMiss + 1;
          if (nMiss == UNLOCKN) begin nMode = UNL; nMiss = 0; end
        end
      end
      mMode <= nMode; mRun <= nRun; mMiss <= nMiss;
      mBx   <= (c[0] || lastBx) ? 0 : mBx + 1;
      eBcr <= c[0]; eL1a <= c[1] && wasLocked; eLr <= c[2]; eBc <= c[3]; eCal <= c[5];
      if (clear_counters) begin
        cL1a <= 0; cSbe <= 0; cDbe <= 0; cMis <= 0;
      end else begin
        cL1a <= satAt(cL1a + ((c[1] && wasLocked) ? 1 : 0), 64'hFFFF_FFFF);
        cMis <= satAt(cMis + (mis ? 1 : 0), 65535);
        cSbe <= ERR_EN ? satAt(cSbe + ((sFlo == 1) ? 1 : 0) + ((sFhi == 1) ? 1 : 0), 65535) : 0;
        cDbe <= ERR_EN ? satAt(cDbe + (dbeW ? 1 : 0), 65535) : 0;
      end
      sCmd <= curCmd; sFlo <= curFlo; sFhi <= curFhi;
    end
  end

  always @(negedge clk_bx) begin
    if (checkOn) begin
      checkOutput("bcr", 32'(bcr), 32'(eBcr));
      checkOutput("l1a", 32'(l1a), 32'(eL1a));
      checkOutput("link_reset", 32'(link_reset), 32'(eLr));
      checkOutput("buffer_clear", 32'(buffer_clear), 32'(eBc));
      checkOutput("calib_pulse", 32'(calib_pulse), 32'(eCal));
      checkOutput("bxid", 32'(bxid), 32'(mBx));
      checkOutput("locked", 32'(locked), 32'(mMode == LCK));
      checkOutput("l1a_count", l1a_count, 32'(cL1a));
      checkOutput("sbe_count", 32'(sbe_count), 32'(cSbe));
      checkOutput("dbe_count", 32'(dbe_count), 32'(cDbe));
      checkOutput("misalign_count", 32'(misalign_count), 32'(cMis));
    end
  end

  // Hand-computed values; outputs seen after call n belong to the word of call n-2.
  task automatic checkLiterals(input int n);
    case (n)
      2: begin
        @(negedge clk_bx);
        checkOutput("lit_reset_locked", 32'(locked), 32'd0);
        checkOutput("lit_reset_bxid", 32'(bxid), 32'd0);
        checkOutput("lit_reset_l1a_count", l1a_count, 32'd0);
      end
      146: begin
        @(negedge clk_bx);
        checkOutput("lit_prelock", 32'(locked), 32'd0);
      end
      147: begin
        @(negedge clk_bx);
        checkOutput("lit_lock_rise", 32'(locked), 32'd1);
        checkOutput("lit_lock_bcr", 32'(bcr), 32'd1);
        checkOutput("lit_lock_bxid", 32'(bxid), 32'd0);
      end
      164: begin
        @(negedge clk_bx);
        checkOutput("lit_l1a_pulse", 32'(l1a), 32'd1);
        checkOutput("lit_l1a_bxid", 32'(bxid), 32'd17);
        checkOutput("lit_l1a_count1", l1a_count, 32'd1);
      end
      167: begin
        @(negedge clk_bx);
        checkOutput("lit_sbe_l1a", 32'(l1a), 32'd1);
        checkOutput("lit_sbe_l1a_count", l1a_count, 32'd2);
        checkOutput("lit_sbe_count", 32'(sbe_count), ERR_EN ? 32'd2 : 32'd0);
      end
      170: begin
        @(negedge clk_bx);
        checkOutput("lit_dbe_l1a", 32'(l1a), 32'd0);
        checkOutput("lit_dbe_l1a_count", l1a_count, 32'd2);
        checkOutput("lit_dbe_count", 32'(dbe_count), ERR_EN ? 32'd1 : 32'd0);
      end
      173: begin
        @(negedge clk_bx);
        checkOutput("lit_calib", 32'(calib_pulse), 32'd1);
        checkOutput("lit_bufclr", 32'(buffer_clear), 32'd1);
        checkOutput("lit_ignored_bits", 32'({bcr, l1a, link_reset}), 32'd0);
      end
      192: begin
        @(negedge clk_bx);
        checkOutput("lit_still_locked", 32'(locked), 32'd1);
        checkOutput("lit_no_misalign", 32'(misalign_count), 32'd0);
      end
      222: begin
        @(negedge clk_bx);
        checkOutput("lit_mis1_count", 32'(misalign_count), 32'd1);
        checkOutput("lit_mis1_locked", 32'(locked), 32'd1);
      end
      252: begin
        @(negedge clk_bx);
        checkOutput("lit_mis2_count", 32'(misalign_count), 32'd2);
        checkOutput("lit_mis2_unlocked", 32'(locked), 32'd0);
      end
      257: begin
        @(negedge clk_bx);
        checkOutput("lit_l1a_suppressed", 32'(l1a), 32'd0);
        checkOutput("lit_l1a_count_held", l1a_count, 32'd2);
      end
      402: begin
        @(negedge clk_bx);
        checkOutput("lit_relock", 32'(locked), 32'd1);
      end
      405: begin
        @(negedge clk_bx);
        checkOutput("lit_clr_l1a", 32'(l1a), 32'd1);
        checkOutput("lit_clr_l1a_count", l1a_count, 32'd0);
        checkOutput("lit_clr_misalign", 32'(misalign_count), 32'd0);
      end
      408: begin
        @(negedge clk_bx);
        checkOutput("lit_pre_linkrst", 32'(locked), 32'd1);
      end
      409: begin
        @(negedge clk_bx);
        checkOutput("lit_linkrst_unlock", 32'(locked), 32'd0);
        checkOutput("lit_linkrst_pulse", 32'(link_reset), 32'd1);
      end
      472: begin
        @(negedge clk_bx);
        checkOutput("lit_reset_drops_lock", 32'(locked), 32'd0);
        checkOutput("lit_reset_bcr_bxid", 32'(bxid), 32'd0);
      end
      517: begin
        @(negedge clk_bx);
        checkOutput("lit_bcr_lr_bxid", 32'(bxid), 32'd0);
        checkOutput("lit_bcr_lr_pulse", 32'({bcr, link_reset}), 32'd3);
        checkOutput("lit_bcr_lr_locked", 32'(locked), 32'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [7:0] cmd;
    int         flo, fhi;
    logic       clr, rst;
    reset          = 1'b1;
    clear_counters = 1'b0;
    fc_stream_enc  = 16'h0000;
    orb_length     = 12'(ORB);
    for (int n = 0; n < 525; n++) begin
      cmd = 8'h00; flo = 0; fhi = 0; clr = 1'b0;
      rst = (n < 3) || (n == 415) || (n == 416);
      case (n)
        10, 55, 100, 145, 190, 220, 250,
        265, 310, 355, 400, 425, 470: cmd = 8'h01;
        162, 255, 403:               cmd = 8'h02;
        165: begin cmd = 8'h02; flo = 1; fhi = 1; end
        168: begin cmd = 8'h02; flo = 2; end
        171:                         cmd = 8'hF8;
        404:                         clr = 1'b1;
        407:                         cmd = 8'h04;
        515:                         cmd = 8'h05;
        default: ;
      endcase
      applyStimulus(cmd, flo, fhi, clr, rst);
      if (n == 0) checkOn = 1'b1;
      checkLiterals(n);
    end
    applyStimulus(8'h00, 0, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 0, 0, 1'b0, 1'b0);
    @(negedge clk_bx);
    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/fc_decoder.md
FC_DECODER -- requirements
Module: fc_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3: number of consecutive aligned BCRs required to enter LOCKED.
REQ-002 SHALL have parameter UNLOCK_COUNT, default 2: number of consecutive BCR misalignments in LOCKED that force UNLOCKED.
REQ-003 clk_bx  in  1  bunch-crossing clock; the only clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fc_stream_enc  in  16  encoded fast-control word: [7:0] Hamming(8,4) of cmd[3:0], [15:8] Hamming(8,4) of cmd[7:4].
REQ-006 orb_length  in  12  orbit length in BX; quasi-static; legal range 2..4095.
REQ-007 clear_counters  in  1  one-cycle pulse that zeroes all counters.
REQ-008 bcr, l1a, link_reset, buffer_clear  out  1 each  decoded single-cycle command pulses (cmd bits 0..3).
REQ-009 calib_pulse  out  1  decoded cmd bit 5, passed as a level.
REQ-010 bxid  out  12  local BX counter, valid in the same cycle as the command outputs.
REQ-011 locked  out  1  high in LOCKED.
REQ-012 l1a_count  out  32; sbe_count  out  16; dbe_count  out  16; misalign_count  out  16.

Function
REQ-013 SHALL register fc_stream_enc, decode both nibbles in sub-module instances, and register the outputs; latency from input to command output SHALL be exactly 2 clk_bx.
REQ-014 Single-bit errors in a nibble SHALL be corrected; each corrected nibble SHALL increment sbe_count by 1, so one word can add up to 2.
REQ-015 A double-bit error in either nibble SHALL zero all 8 cmd bits for that cycle and increment dbe_count by 1.
REQ-016 Cmd bits 4, 6 and 7 SHALL be ignored.
REQ-017 bxid SHALL load 0 on a decoded BCR; otherwise it SHALL wrap to 0 when bxid==orb_length-1, and increment in all other cases.
REQ-018 A BCR SHALL be aligned when the pre-update bxid==orb_length-1; otherwise it is misaligned.
REQ-019 In LOCKED, bxid==orb_length-1 with no BCR SHALL also count as misaligned.
REQ-020 FSM states: UNLOCKED, CHECK, LOCKED; reset state is UNLOCKED.
REQ-021 UNLOCKED->CHECK on any BCR; this clears the alignment run counter.
REQ-022 CHECK->LOCKED after LOCK_COUNT consecutive aligned BCRs; a misaligned BCR in CHECK restarts the run at 0 and stays in CHECK.
REQ-023 LOCKED->UNLOCKED after UNLOCK_COUNT consecutive misalignments; an aligned BCR clears the miss run.
REQ-024 Every misalignment in LOCKED SHALL increment misalign_count.
REQ-025 A decoded link_reset SHALL force UNLOCKED in any state, with priority over a simultaneous BCR transition; the BCR still loads bxid=0.
REQ-026 l1a SHALL be output only in LOCKED; l1a_count increments only on an output l1a.
REQ-027 The other commands SHALL pass in all states.
REQ-028 All counters SHALL saturate at all-ones, not wrap.
REQ-029 clear_counters SHALL take priority over a simultaneous increment (result 0).

Reset
REQ-030 On reset all outputs SHALL be 0, the FSM SHALL be UNLOCKED, the run counters SHALL be 0, and the pipeline registers SHALL be cleared, so no spurious command appears within 2 cycles after reset.
REQ-031 Reset mid-orbit SHALL discard lock; relock SHALL require a full LOCK_COUNT sequence.

Configuration
REQ-032 Macro FC_DECODER_ERR_CNT_EN: when defined, sbe_count and dbe_count SHALL be implemented per REQ-014/015.
REQ-033 When FC_DECODER_ERR_CNT_EN is undefined, sbe_count and dbe_count SHALL be tied to 0; correction and DBE discard remain unchanged.

Structure
REQ-034 A shared package SHALL hold the cmd bit index constants (BCR=0, L1A=1, LINK_RESET=2, BUFFER_CLEAR=3, CALIB=5), the FSM state enum, and the counter widths.
REQ-035 Sub-module hamming84_dec (8-bit in; 4-bit data, sbe, dbe out, combinational) SHALL be instantiated twice.

Verification
REQ-036 orb_length=45; BCR every 45 cycles, clean stream -> locked rises 2 cycles after the 4th BCR (the first enters CHECK, the next 3 are aligned); misalign_count=0.
REQ-037 Locked; L1A sent when bxid=17 -> l1a pulses with bxid=17, 2 cycles after input; l1a_count=1.
REQ-038 Flip 1 bit in fc_stream_enc[15:8] and 1 bit in [7:0] of an L1A word -> l1a still emitted; sbe_count +=2.
REQ-039 Flip 2 bits in [7:0] of an L1A word -> no l1a; dbe_count=1.
REQ-040 Locked; 2 consecutive BCRs arrive at bxid=30 -> misalign_count=2, locked falls; L1A afterwards is suppressed.
REQ-041 link_reset while locked -> locked=0 next output cycle; with the macro undefined, sbe_count and dbe_count stay 0 under the injected errors.
